// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// Handshake: the datapath presents mem_ready=1 in the cycle its memory access
// completes. The controller holds its request outputs stable while mem_ready=0.
// An access is consumed on the rising edge where mem_ready=1.
interface multicycle_ctrl_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       fault;
    logic [3:0] state_dbg;

    // Controller side.
    modport master (
        input  Op, Funct, mem_ready,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, fault, state_dbg
    );

    // Datapath side.
    modport slave (
        output Op, Funct, mem_ready,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, fault, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main sequencer for the multicycle ARM datapath. A Moore FSM walks the
// fetch/decode/execute/memory/writeback steps. The write requests it raises are
// unconditional and get condition-gated downstream. Memory waits in FETCH, MEMRD
// and MEMWR are bounded by a timeout counter that aborts back to FETCH with a
// one-cycle fault pulse. TIMEOUT must not exceed 2**CNT_W-1; TIMEOUT=0 disables it.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        UNDEF  = 4'd10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic             TO_EN     = (TIMEOUT != 0);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_fault;
    logic             w_fault_next;
    logic             w_wait;
    logic             w_abort;
    logic             w_unused;

    // Only the I and L bits of Funct steer the sequencer; the rest go to the ALU decoder.
    assign w_unused = ^bus.Funct[4:1];

    // Next state, timeout abort, counter update and fault pulse.
    always_comb begin
        w_next       = r_state;
        w_cnt_next   = '0;
        w_fault_next = 1'b0;
        w_wait       = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
        // A completing access in the same cycle as the limit wins over the abort.
        w_abort      = TO_EN && w_wait && !bus.mem_ready && (r_cnt == CNT_LIMIT);

        case (r_state)
            FETCH:  if (bus.mem_ready) w_next = DECODE;
            DECODE: begin
                case (bus.Op)
                    2'b00:   w_next = bus.Funct[5] ? EXECI : EXECR;
                    2'b01:   w_next = MEMADR;
                    2'b10:   w_next = BRANCH;
                    default: w_next = UNDEF;
                endcase
            end
            MEMADR: w_next = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (bus.mem_ready) w_next = MEMWB;
            MEMWR:  if (bus.mem_ready) w_next = FETCH;
            EXECR:  w_next = ALUWB;
            EXECI:  w_next = ALUWB;
            default: w_next = FETCH;
        endcase

        if (w_abort) begin
            w_next = FETCH;
        end

        // Count only while sitting in the same wait state without completion;
        // entry into a wait state, completion and abort all restart from zero.
        if (w_wait && !w_abort && !bus.mem_ready && (w_next == r_state)) begin
            w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end

        w_fault_next = w_abort || ((r_state == DECODE) && (bus.Op == 2'b11));
    end

    // State, timeout counter and fault registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_fault <= w_fault_next;
        end
    end

    // Moore output decode; IRWrite/NextPC additionally wait for the fetch to complete.
    always_comb begin
        bus.IRWrite   = 1'b0;
        bus.NextPC    = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        bus.ALUOp     = 1'b0;
        bus.RegW      = 1'b0;
        bus.MemW      = 1'b0;
        bus.Branch    = 1'b0;
        bus.fault     = r_fault;
        bus.state_dbg = r_state;

        case (r_state)
            FETCH: begin
                // Reset is folded in so no PC/IR write can escape while held in reset.
                bus.IRWrite   = bus.mem_ready && reset;
                bus.NextPC    = bus.mem_ready && reset;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            MEMADR: begin
                bus.ALUSrcB   = 2'b01;
            end
            MEMRD: begin
                bus.AdrSrc    = 1'b1;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegW      = 1'b1;
            end
            MEMWR: begin
                bus.AdrSrc    = 1'b1;
                bus.MemW      = 1'b1;
            end
            EXECR: begin
                bus.ALUOp     = 1'b1;
            end
            EXECI: begin
                bus.ALUSrcB   = 2'b01;
                bus.ALUOp     = 1'b1;
            end
            ALUWB: begin
                bus.RegW      = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.Branch    = 1'b1;
            end
            default: begin
                // UNDEF: every request stays at its default of 0.
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: reset, ALU register op, load with wait
// states, store timeout, undefined op, branch, limit-cycle completion and reset
// during a store.
module tb_multicycle_ctrl;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_UNDEF  = 4'd10;

    // Expected Moore outputs per state, packed as
    // {AdrSrc, ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], ALUOp, RegW, MemW, Branch}
    localparam logic [10:0] O_FETCH  = 11'b0_01_10_10_0000;
    localparam logic [10:0] O_DECODE = 11'b0_01_10_10_0000;
    localparam logic [10:0] O_MEMADR = 11'b0_00_01_00_0000;
    localparam logic [10:0] O_MEMRD  = 11'b1_00_00_00_0000;
    localparam logic [10:0] O_MEMWB  = 11'b0_00_00_01_0100;
    localparam logic [10:0] O_MEMWR  = 11'b1_00_00_00_0010;
    localparam logic [10:0] O_EXECR  = 11'b0_00_00_00_1000;
    localparam logic [10:0] O_ALUWB  = 11'b0_00_00_00_0100;
    localparam logic [10:0] O_BRANCH = 11'b0_00_01_10_0001;
    localparam logic [10:0] O_UNDEF  = 11'b0_00_00_00_0000;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and run-time guard.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    // Compares the full observed output vector against the expected one.
    task automatic chk(input string tag, input logic [3:0] st, input logic [10:0] o,
                       input logic irw, input logic flt);
        logic [17:0] obs;
        logic [17:0] exp_v;
        obs = {bus.state_dbg, bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA,
               bus.ALUSrcB, bus.ResultSrc, bus.ALUOp, bus.RegW, bus.MemW,
               bus.Branch, bus.fault};
        exp_v = {st, irw, irw, o, flt};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock edge, then drive inputs for the new cycle and let them settle.
    task automatic step(input logic mr, input logic [1:0] op, input logic [5:0] funct);
        @(posedge clk);
        #2;
        bus.mem_ready = mr;
        bus.Op        = op;
        bus.Funct     = funct;
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.Op        = 2'b00;
        bus.Funct     = 6'b000000;

        // 1. Held in reset for 3 cycles: FETCH, no write requests even with mem_ready=1.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00, 6'b000000);
            chk("reset_hold", S_FETCH, O_FETCH, 1'b0, 1'b0);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_release_fetch", S_FETCH, O_FETCH, 1'b1, 1'b0);

        // 2. ADD register form: DECODE, EXECR, ALUWB, FETCH.
        step(1'b1, 2'b00, 6'b001000);
        chk("add_decode", S_DECODE, O_DECODE, 1'b0, 1'b0);
        step(1'b1, 2'b00, 6'b001000);
        chk("add_execr", S_EXECR, O_EXECR, 1'b0, 1'b0);
        step(1'b1, 2'b00, 6'b001000);
        chk("add_aluwb", S_ALUWB, O_ALUWB, 1'b0, 1'b0);
        step(1'b1, 2'b00, 6'b001000);
        chk("add_fetch", S_FETCH, O_FETCH, 1'b1, 1'b0);

        // 3. LDR with three wait cycles in MEMRD.
        step(1'b1, 2'b01, 6'b011001);
        chk("ldr_decode", S_DECODE, O_DECODE, 1'b0, 1'b0);
        step(1'b1, 2'b01, 6'b011001);
        chk("ldr_memadr", S_MEMADR, O_MEMADR, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b01, 6'b011001);
            chk("ldr_memrd_wait", S_MEMRD, O_MEMRD, 1'b0, 1'b0);
        end
        step(1'b1, 2'b01, 6'b011001);
        chk("ldr_memrd_done", S_MEMRD, O_MEMRD, 1'b0, 1'b0);
        step(1'b1, 2'b01, 6'b011001);
        chk("ldr_memwb", S_MEMWB, O_MEMWB, 1'b0, 1'b0);
        step(1'b1, 2'b01, 6'b011000);
        chk("ldr_fetch", S_FETCH, O_FETCH, 1'b1, 1'b0);

        // 4. STR that never completes: 16 MEMWR cycles with MemW, then abort with fault.
        step(1'b1, 2'b01, 6'b011000);
        chk("str_decode", S_DECODE, O_DECODE, 1'b0, 1'b0);
        step(1'b0, 2'b01, 6'b011000);
        chk("str_memadr", S_MEMADR, O_MEMADR, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 2'b01, 6'b011000);
            chk($sformatf("str_memwr_%0d", i), S_MEMWR, O_MEMWR, 1'b0, 1'b0);
        end
        step(1'b0, 2'b01, 6'b011000);
        chk("str_abort_fault", S_FETCH, O_FETCH, 1'b0, 1'b1);
        step(1'b1, 2'b11, 6'b000000);
        chk("str_fault_cleared", S_FETCH, O_FETCH, 1'b1, 1'b0);

        // 5. Undefined op, then a branch.
        step(1'b1, 2'b11, 6'b000000);
        chk("undef_decode", S_DECODE, O_DECODE, 1'b0, 1'b0);
        step(1'b1, 2'b11, 6'b000000);
        chk("undef_state", S_UNDEF, O_UNDEF, 1'b0, 1'b1);
        step(1'b1, 2'b10, 6'b000000);
        chk("undef_to_fetch", S_FETCH, O_FETCH, 1'b1, 1'b0);
        step(1'b1, 2'b10, 6'b000000);
        chk("b_decode", S_DECODE, O_DECODE, 1'b0, 1'b0);
        step(1'b1, 2'b10, 6'b000000);
        chk("b_branch", S_BRANCH, O_BRANCH, 1'b0, 1'b0);

        // 6a. Fetch completes exactly on the limit cycle: no abort, no fault.
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 2'b01, 6'b011000);
            chk($sformatf("fetch_wait_%0d", i), S_FETCH, O_FETCH, 1'b0, 1'b0);
        end
        step(1'b1, 2'b01, 6'b011000);
        chk("fetch_limit_ready", S_FETCH, O_FETCH, 1'b1, 1'b0);
        step(1'b1, 2'b01, 6'b011000);
        chk("fetch_limit_decode", S_DECODE, O_DECODE, 1'b0, 1'b0);

        // 6b. Reset asserted mid-MEMWR drops MemW without waiting for a clock edge.
        step(1'b0, 2'b01, 6'b011000);
        chk("rst_str_memadr", S_MEMADR, O_MEMADR, 1'b0, 1'b0);
        step(1'b0, 2'b01, 6'b011000);
        chk("rst_str_memwr", S_MEMWR, O_MEMWR, 1'b0, 1'b0);
        step(1'b0, 2'b01, 6'b011000);
        chk("rst_str_memwr2", S_MEMWR, O_MEMWR, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_async_memw_drop", S_FETCH, O_FETCH, 1'b0, 1'b0);
        step(1'b1, 2'b00, 6'b000000);
        chk("rst_async_hold", S_FETCH, O_FETCH, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_async_release", S_FETCH, O_FETCH, 1'b1, 1'b0);
        step(1'b1, 2'b00, 6'b100000);
        chk("rst_after_decode", S_DECODE, O_DECODE, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
